// File: rtl/fp_pkg.sv
// Shared types for the FP result path: opcode tags, result sources and arbiter FSM states.
package fp_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_SIN = 3'd3,
    OP_COS = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    SRC_ADD  = 2'd0,
    SRC_MUL  = 2'd1,
    SRC_SINE = 2'd2
  } src_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_SRC = 3;

  // Round-robin successor; the unused encoding folds back to ADD.
  function automatic src_t src_next(src_t s);
    case (s)
      SRC_ADD: return SRC_MUL;
      SRC_MUL: return SRC_SINE;
      default: return SRC_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way combinational round-robin pick: first requester at or after ptr_i.
module rr_arbiter3
  import fp_pkg::*;
(
  input  logic [2:0] req_i,
  input  src_t       ptr_i,
  output logic       gnt_valid_o,
  output src_t       gnt_o
);

  src_t order [3];

  always_comb begin
    order[0] = ((ptr_i == SRC_MUL) || (ptr_i == SRC_SINE)) ? ptr_i : SRC_ADD;
    order[1] = src_next(order[0]);
    order[2] = src_next(order[1]);
    gnt_valid_o = 1'b0;
    gnt_o       = SRC_ADD;
    // Scan from lowest priority up so the highest-priority requester wins last.
    for (int k = 2; k >= 0; k--) begin
      if (req_i[order[k]]) begin
        gnt_valid_o = 1'b1;
        gnt_o       = order[k];
      end
    end
  end

endmodule

// File: rtl/fp_result_arbiter.sv
// Buffers add/mul/sine results in one-entry holding registers and serialises them
// onto the single output-FIFO write port with round-robin arbitration.
module fp_result_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    n_rst_i,
  input  logic                    add_done_i,
  input  logic [DATA_W-1:0]       add_result_i,
  input  logic [TAG_W-1:0]        add_op_i,
  input  logic                    mul_done_i,
  input  logic [DATA_W-1:0]       mul_result_i,
  input  logic [TAG_W-1:0]        mul_op_i,
  input  logic                    sine_done_i,
  input  logic [DATA_W-1:0]       sine_result_i,
  input  logic [TAG_W-1:0]        sine_op_i,
  input  logic                    fifo_full_i,
  output logic                    add_hold_o,
  output logic                    mul_hold_o,
  output logic                    sine_hold_o,
  output logic                    fifo_wr_o,
  output logic [TAG_W+DATA_W-1:0] fifo_wdata_o,
  output logic                    out_fifo_hold_o,
  output logic                    overflow_err_o,
  output logic [CNT_W-1:0]        result_count_o
);

  logic [2:0]        done;
  logic [DATA_W-1:0] res [NUM_SRC];
  logic [TAG_W-1:0]  op  [NUM_SRC];

  logic [2:0]              pend_q, pend_d;
  logic [DATA_W-1:0]       data_q [NUM_SRC];
  logic [DATA_W-1:0]       data_d [NUM_SRC];
  logic [TAG_W-1:0]        tag_q  [NUM_SRC];
  logic [TAG_W-1:0]        tag_d  [NUM_SRC];
  arb_state_t              state_q, state_d;
  src_t                    rr_ptr_q, rr_ptr_d;
  logic                    fifo_wr_q, fifo_wr_d;
  logic [TAG_W+DATA_W-1:0] fifo_wdata_q, fifo_wdata_d;
  logic                    overflow_q, overflow_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic       gnt_valid;
  src_t       gnt;
  logic       grant_en;
  logic [2:0] grant_vec;

  always_comb begin
    done   = {sine_done_i, mul_done_i, add_done_i};
    res[0] = add_result_i;
    res[1] = mul_result_i;
    res[2] = sine_result_i;
    op[0]  = add_op_i;
    op[1]  = mul_op_i;
    op[2]  = sine_op_i;
  end

  rr_arbiter3 u_rr_arbiter3 (
    .req_i       (pend_q),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  always_comb begin
    grant_en  = (state_q == IDLE) && !fifo_full_i && gnt_valid;
    grant_vec = '0;
    if (grant_en) grant_vec[gnt] = 1'b1;

    pend_d       = pend_q;
    data_d       = data_q;
    tag_d        = tag_q;
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    overflow_d   = overflow_q;
    count_d      = count_q;

    // A granted slot frees up on this edge, so a same-cycle done may refill it.
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (grant_vec[i]) pend_d[i] = 1'b0;
      if (done[i]) begin
        if (!pend_q[i] || grant_vec[i]) begin
          pend_d[i] = 1'b1;
          data_d[i] = res[i];
          tag_d[i]  = op[i];
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          fifo_wdata_d = {tag_q[gnt], data_q[gnt]};
          rr_ptr_d     = src_next(gnt);
          state_d      = WRITE;
          fifo_wr_d    = 1'b1;
        end
      end
      WRITE: begin
        count_d = count_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      pend_q       <= '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      state_q      <= IDLE;
      rr_ptr_q     <= SRC_ADD;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      overflow_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      pend_q       <= pend_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      overflow_q   <= overflow_d;
      count_q      <= count_d;
    end
  end

  assign add_hold_o      = pend_q[0];
  assign mul_hold_o      = pend_q[1];
  assign sine_hold_o     = pend_q[2];
  assign fifo_wr_o       = fifo_wr_q;
  assign fifo_wdata_o    = fifo_wdata_q;
  assign overflow_err_o  = overflow_q;
  assign result_count_o  = count_q;
  assign out_fifo_hold_o = fifo_full_i | (pend_q[0] & pend_q[1]) | (pend_q[0] & pend_q[2]) |
                           (pend_q[1] & pend_q[2]);

endmodule

// File: tb/tb_fp_result_arbiter.sv
// Self-checking bench for fp_result_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_fp_result_arbiter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        add_done = 1'b0, mul_done = 1'b0, sine_done = 1'b0, fifo_full = 1'b0;
  logic [31:0] add_result = '0, mul_result = '0, sine_result = '0;
  logic [2:0]  add_op = '0, mul_op = '0, sine_op = '0;

  logic        add_hold, mul_hold, sine_hold, fifo_wr, out_fifo_hold, overflow_err;
  logic [34:0] fifo_wdata;
  logic [15:0] result_count;
  logic        s_add_hold, s_mul_hold, s_sine_hold, s_fifo_wr, s_out_fifo_hold, s_overflow_err;
  logic [34:0] s_fifo_wdata;
  logic [3:0]  s_result_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_pend [3];
  logic [31:0] m_data [3];
  logic [2:0]  m_tag  [3];
  bit          m_busy, m_wr, m_ovf;
  int          m_ptr;
  logic [34:0] m_wdata;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  fp_result_arbiter u_dut (
    .clk_i (clk), .n_rst_i (n_rst),
    .add_done_i (add_done), .add_result_i (add_result), .add_op_i (add_op),
    .mul_done_i (mul_done), .mul_result_i (mul_result), .mul_op_i (mul_op),
    .sine_done_i (sine_done), .sine_result_i (sine_result), .sine_op_i (sine_op),
    .fifo_full_i (fifo_full),
    .add_hold_o (add_hold), .mul_hold_o (mul_hold), .sine_hold_o (sine_hold),
    .fifo_wr_o (fifo_wr), .fifo_wdata_o (fifo_wdata), .out_fifo_hold_o (out_fifo_hold),
    .overflow_err_o (overflow_err), .result_count_o (result_count)
  );

  // Narrow-counter copy used to exercise counter wrap within a short run.
  fp_result_arbiter #(.DATA_W (32), .TAG_W (3), .CNT_W (4)) u_dut_small (
    .clk_i (clk), .n_rst_i (n_rst),
    .add_done_i (add_done), .add_result_i (add_result), .add_op_i (add_op),
    .mul_done_i (mul_done), .mul_result_i (mul_result), .mul_op_i (mul_op),
    .sine_done_i (sine_done), .sine_result_i (sine_result), .sine_op_i (sine_op),
    .fifo_full_i (fifo_full),
    .add_hold_o (s_add_hold), .mul_hold_o (s_mul_hold), .sine_hold_o (s_sine_hold),
    .fifo_wr_o (s_fifo_wr), .fifo_wdata_o (s_fifo_wdata), .out_fifo_hold_o (s_out_fifo_hold),
    .overflow_err_o (s_overflow_err), .result_count_o (s_result_count)
  );

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_pend[s] = 1'b0; m_data[s] = '0; m_tag[s] = '0;
    end
    m_busy = 1'b0; m_wr = 1'b0; m_ovf = 1'b0; m_ptr = 0; m_wdata = '0; m_cnt = 0;
  endtask

  task automatic clear_inputs();
    add_done = 1'b0; mul_done = 1'b0; sine_done = 1'b0;
  endtask

  // One clock edge: the model consumes the inputs that were present at the edge.
  task automatic step();
    bit          d [3];
    logic [31:0] r [3];
    logic [2:0]  o [3];
    bit          old [3];
    bit          full;
    int          win;
    d[0] = add_done; d[1] = mul_done; d[2] = sine_done;
    r[0] = add_result; r[1] = mul_result; r[2] = sine_result;
    o[0] = add_op; o[1] = mul_op; o[2] = sine_op;
    full = fifo_full;
    @(posedge clk);
    old = m_pend;
    win = -1;
    m_wr = 1'b0;
    if (m_busy) begin
      m_busy = 1'b0;
      m_cnt  = m_cnt + 1;
    end else if (!full) begin
      for (int k = 0; k < 3; k++)
        if (win < 0 && m_pend[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
      if (win >= 0) begin
        m_wdata      = {m_tag[win], m_data[win]};
        m_pend[win]  = 1'b0;
        m_ptr        = (win + 1) % 3;
        m_busy       = 1'b1;
        m_wr         = 1'b1;
      end
    end
    for (int s = 0; s < 3; s++) begin
      if (d[s]) begin
        if (old[s] && s != win) m_ovf = 1'b1;
        else begin
          m_pend[s] = 1'b1; m_data[s] = r[s]; m_tag[s] = o[s];
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    fifo_full = 1'b0;
    n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    n_rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({fifo_wr, fifo_wdata, overflow_err, result_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr=%b wdata=%h ovf=%b cnt=%0d, expected all 0",
               fifo_wr, fifo_wdata, overflow_err, result_count);
    end
    n_checks++;
    if ({add_hold, mul_hold, sine_hold, out_fifo_hold} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_holds: got %b, expected 0000",
               {add_hold, mul_hold, sine_hold, out_fifo_hold});
    end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_single_add();
    add_done = 1'b1; add_result = 32'h3F80_0000; add_op = 3'd0;
    step();
    clear_inputs();
    n_checks++;
    if (add_hold !== 1'b1 || fifo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL single_capture: got hold=%b wr=%b, expected hold=1 wr=0", add_hold, fifo_wr);
    end
    step();
    n_checks++;
    if (fifo_wr !== 1'b1 || fifo_wdata !== {3'd0, 32'h3F80_0000}) begin
      n_fail++;
      $display("FAIL single_write: got wr=%b wdata=%h, expected wr=1 wdata=%h",
               fifo_wr, fifo_wdata, {3'd0, 32'h3F80_0000});
    end
    step();
    n_checks++;
    if (fifo_wr !== 1'b0 || result_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_count: got wr=%b cnt=%0d, expected wr=0 cnt=1", fifo_wr, result_count);
    end
  endtask

  task automatic test_all_three();
    logic [34:0] exp_w [3];
    do_reset();
    for (int round = 0; round < 2; round++) begin
      add_done = 1'b1; mul_done = 1'b1; sine_done = 1'b1;
      add_result = $urandom; mul_result = $urandom; sine_result = $urandom;
      add_op = 3'd0; mul_op = 3'd2; sine_op = 3'd3;
      exp_w[0] = {add_op, add_result};
      exp_w[1] = {mul_op, mul_result};
      exp_w[2] = {sine_op, sine_result};
      step();
      clear_inputs();
      for (int k = 0; k < 6; k++) begin
        step();
        n_checks++;
        if (k % 2 == 0) begin
          if (fifo_wr !== 1'b1 || fifo_wdata !== exp_w[k / 2]) begin
            n_fail++;
            $display("FAIL rr_order r%0d s%0d: got wr=%b wdata=%h, expected wr=1 wdata=%h",
                     round, k, fifo_wr, fifo_wdata, exp_w[k / 2]);
          end
        end else if (fifo_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_gap r%0d s%0d: got wr=%b, expected 0", round, k, fifo_wr);
        end
      end
    end
  endtask

  task automatic test_fifo_full_hold();
    logic [34:0] exp_w;
    fifo_full = 1'b1;
    mul_done = 1'b1; mul_result = $urandom; mul_op = 3'd2;
    exp_w = {mul_op, mul_result};
    step();
    clear_inputs();
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (fifo_wr !== 1'b0 || mul_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL full_stall c%0d: got wr=%b mul_hold=%b, expected wr=0 mul_hold=1",
                 k, fifo_wr, mul_hold);
      end
      step();
    end
    fifo_full = 1'b0;
    step();
    n_checks++;
    if (fifo_wr !== 1'b1 || fifo_wdata !== exp_w || mul_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL full_release: got wr=%b wdata=%h hold=%b, expected wr=1 wdata=%h hold=0",
               fifo_wr, fifo_wdata, mul_hold, exp_w);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [34:0] first_w;
    fifo_full = 1'b1;
    add_done = 1'b1; add_result = $urandom; add_op = 3'd1;
    first_w = {add_op, add_result};
    step();
    add_result = ~add_result; add_op = 3'd0;
    step();
    clear_inputs();
    n_checks++;
    if (overflow_err !== 1'b1 || add_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf=%b hold=%b, expected 1 1", overflow_err, add_hold);
    end
    repeat (3) step();
    fifo_full = 1'b0;
    step();
    n_checks++;
    if (fifo_wr !== 1'b1 || fifo_wdata !== first_w) begin
      n_fail++;
      $display("FAIL overflow_keep_first: got wr=%b wdata=%h, expected wr=1 wdata=%h",
               fifo_wr, fifo_wdata, first_w);
    end
    step();
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b, expected 1", overflow_err);
    end
  endtask

  task automatic test_out_fifo_hold();
    do_reset();
    add_done = 1'b1; mul_done = 1'b1; add_result = $urandom; mul_result = $urandom;
    step();
    clear_inputs();
    n_checks++;
    if (out_fifo_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL ofh_two_pending: got %b, expected 1", out_fifo_hold);
    end
    step();
    n_checks++;
    if (out_fifo_hold !== 1'b0 || mul_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL ofh_one_pending: got ofh=%b mul_hold=%b, expected 0 1",
               out_fifo_hold, mul_hold);
    end
    repeat (3) step();
    fifo_full = 1'b1;
    #1;
    n_checks++;
    if (out_fifo_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL ofh_full: got %b, expected 1", out_fifo_hold);
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      add_done = 1'b1; add_result = $urandom; add_op = 3'($urandom_range(0, 4));
      step();
      clear_inputs();
      step();
    end
    step();
    n_checks++;
    if (s_result_count !== 4'd0 || result_count !== 16'd16) begin
      n_fail++;
      $display("FAIL count_wrap: got small=%0d wide=%0d, expected small=0 wide=16",
               s_result_count, result_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      add_done = ($urandom_range(0, 3) == 0); add_result = $urandom; add_op = 3'($urandom_range(0, 4));
      mul_done = ($urandom_range(0, 3) == 0); mul_result = $urandom; mul_op = 3'($urandom_range(0, 4));
      sine_done = ($urandom_range(0, 3) == 0); sine_result = $urandom;
      sine_op = 3'($urandom_range(0, 4));
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
      n_checks++;
      if (fifo_wr !== m_wr || fifo_wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL rnd_write c%0d: got wr=%b wdata=%h, expected wr=%b wdata=%h",
                 c, fifo_wr, fifo_wdata, m_wr, m_wdata);
      end
      n_checks++;
      if ({sine_hold, mul_hold, add_hold} !== {m_pend[2], m_pend[1], m_pend[0]} ||
          out_fifo_hold !== (fifo_full | (int'(m_pend[0]) + int'(m_pend[1]) + int'(m_pend[2]) >= 2))) begin
        n_fail++;
        $display("FAIL rnd_holds c%0d: got %b%b%b ofh=%b, expected %b%b%b", c, sine_hold,
                 mul_hold, add_hold, out_fifo_hold, m_pend[2], m_pend[1], m_pend[0]);
      end
      n_checks++;
      if (overflow_err !== m_ovf || result_count !== 16'(m_cnt) ||
          s_result_count !== 4'(m_cnt)) begin
        n_fail++;
        $display("FAIL rnd_status c%0d: got ovf=%b cnt=%0d small=%0d, expected ovf=%b cnt=%0d",
                 c, overflow_err, result_count, s_result_count, m_ovf, 16'(m_cnt));
      end
    end
    clear_inputs();
    fifo_full = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    add_done = 1'b1; mul_done = 1'b1; sine_done = 1'b1;
    step();
    clear_inputs();
    step();
    n_checks++;
    if (fifo_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got wr=%b, expected 1", fifo_wr);
    end
    n_rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (fifo_wr !== 1'b0 || {add_hold, mul_hold, sine_hold} !== 3'b0 || result_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: got wr=%b holds=%b cnt=%0d, expected 0 000 0",
               fifo_wr, {add_hold, mul_hold, sine_hold}, result_count);
    end
    #3 n_rst = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_single_add();
    test_all_three();
    test_fifo_full_hold();
    test_overflow();
    test_out_fifo_hold();
    test_count_wrap();
    test_random();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
